// File: rtl/pump_pkg.sv
// Shared definitions for the multi-channel pump scheduler: command opcodes,
// pulse engine state encoding and the channel-index width helper.
package pump_pkg;

    localparam logic [1:0] OP_START    = 2'd0;
    localparam logic [1:0] OP_STOP     = 2'd1;
    localparam logic [1:0] OP_MANUAL   = 2'd2;
    localparam logic [1:0] OP_STOP_ALL = 2'd3;

    typedef enum logic [1:0] {
        ENG_IDLE  = 2'd0,
        ENG_PULSE = 2'd1,
        ENG_GAP   = 2'd2
    } eng_state_t;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pump_channel_timer.sv
// One scheduler channel: periodic second-based timer, enable flag and the
// pending request bit that the shared pulse engine consumes.
module pump_channel_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        sec_tick,
    input  logic        start,
    input  logic        stop,
    input  logic        manual,
    input  logic        grant,
    input  logic [31:0] period_in,
    output logic        pump_en,
    output logic        pending
);

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic        en_q, en_d;
    logic        pend_q, pend_d;
    logic        expire;

    // Commands override the tick; MANUAL leaves the timer running so an
    // expiry in the same cycle simply merges into the one pending bit.
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        en_d     = en_q;
        expire   = 1'b0;
        if (start) begin
            period_d = (period_in == 32'd0) ? 32'd1 : period_in;
            cnt_d    = period_d;
            en_d     = 1'b1;
        end else if (stop) begin
            en_d = 1'b0;
        end else if (sec_tick && en_q) begin
            if (cnt_q == 32'd1) begin
                expire = 1'b1;
                cnt_d  = period_q;
            end else begin
                cnt_d = cnt_q - 32'd1;
            end
        end
        pend_d = pend_q | manual | expire;
        if (grant || stop) begin
            pend_d = 1'b0;
        end
    end

    // Channel state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            period_q <= '0;
            en_q     <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            en_q     <= en_d;
            pend_q   <= pend_d;
        end
    end

    assign pump_en = en_q;
    assign pending = pend_q;

endmodule

// File: rtl/pump_scheduler_multi.sv
// Multi-channel fragrance pump scheduler: second prescaler, command decode,
// per-channel timers, round-robin arbiter and a single shared pulse engine.
// Optional feature macro PUMP_PULSE_COUNT_EN adds per-channel 16-bit
// saturating grant counters on output pulse_count.
//
// Engine states:
//   state     | meaning
//   ENG_IDLE  | no pump driven, grants the next pending channel
//   ENG_PULSE | pump_out[active_ch] driven for the pulse length
//   ENG_GAP   | forced idle spacing after a pulse (or a stopped pulse)
module pump_scheduler_multi
    import pump_pkg::*;
#(
    parameter int NUM_PUMPS     = 3,
    parameter int CLOCK_FREQ    = 1_000_000,
    parameter int PULSE_SECONDS = 5,
    parameter int GAP_CYCLES    = 1000,
    parameter int PERIOD0_S     = 1800,
    parameter int PERIOD1_S     = 3600,
    parameter int PERIOD2_S     = 7200,
    parameter int PERIOD3_S     = 1800,
    localparam int CH_W         = ch_width(NUM_PUMPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CH_W-1:0]      cmd_ch,
    input  logic [1:0]           cmd_period,
    output logic                 cmd_err,
    output logic [NUM_PUMPS-1:0] pump_out,
    output logic [NUM_PUMPS-1:0] pump_en,
    output logic [NUM_PUMPS-1:0] pending,
    output logic                 busy,
    output logic [CH_W-1:0]      active_ch
`ifdef PUMP_PULSE_COUNT_EN
    ,
    output logic [16*NUM_PUMPS-1:0] pulse_count
`endif
);

    localparam logic [31:0]     CLK_DIV   = 32'(CLOCK_FREQ);
    localparam logic [31:0]     PULSE_CYC = 32'(PULSE_SECONDS * CLOCK_FREQ);
    localparam logic [31:0]     GAP_CYC   = 32'(GAP_CYCLES);
    localparam logic [CH_W:0]   NUM_CH    = (CH_W + 1)'(NUM_PUMPS);
    localparam logic [CH_W-1:0] LAST_INIT = CH_W'(NUM_PUMPS - 1);

    logic [31:0]          presc_q, presc_d;
    logic                 sec_tick;
    logic                 ready_q;
    logic                 err_q, err_d;
    eng_state_t           state_q, state_d;
    logic [31:0]          eng_cnt_q, eng_cnt_d;
    logic [CH_W-1:0]      active_q, active_d;
    logic [CH_W-1:0]      last_q, last_d;

    logic                 cmd_accept;
    logic                 ch_ok;
    logic [31:0]          period_sel;
    logic [NUM_PUMPS-1:0] start_v, stop_v, manual_v, grant_v;
    logic [NUM_PUMPS-1:0] eligible;
    logic                 grant_found;
    logic [CH_W-1:0]      grant_idx;
    logic [CH_W-1:0]      cand;

    // Free-running second prescaler; commands never disturb its phase.
    always_comb begin
        sec_tick = (presc_q == CLK_DIV - 32'd1);
        presc_d  = sec_tick ? 32'd0 : presc_q + 32'd1;
    end

    // Command decode into per-channel strobes; STOP_ALL ignores cmd_ch.
    always_comb begin
        cmd_accept = cmd_valid && ready_q;
        ch_ok      = ({1'b0, cmd_ch} < NUM_CH);
        start_v    = '0;
        stop_v     = '0;
        manual_v   = '0;
        err_d      = cmd_accept && (cmd_op != OP_STOP_ALL) && !ch_ok;
        if (cmd_accept) begin
            if (cmd_op == OP_STOP_ALL) begin
                stop_v = '1;
            end else if (ch_ok) begin
                for (int i = 0; i < NUM_PUMPS; i++) begin
                    if (cmd_ch == CH_W'(i)) begin
                        start_v[i]  = (cmd_op == OP_START);
                        stop_v[i]   = (cmd_op == OP_STOP);
                        manual_v[i] = (cmd_op == OP_MANUAL);
                    end
                end
            end
        end
        case (cmd_period)
            2'd0:    period_sel = 32'(PERIOD0_S);
            2'd1:    period_sel = 32'(PERIOD1_S);
            2'd2:    period_sel = 32'(PERIOD2_S);
            default: period_sel = 32'(PERIOD3_S);
        endcase
    end

    // Round-robin pick starting after the last granted channel; a channel
    // being stopped this cycle is not eligible.
    always_comb begin
        eligible    = pending & ~stop_v;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_PUMPS; k++) begin
            cand = CH_W'((int'(last_q) + k) % NUM_PUMPS);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Pulse engine next state; a stop of the active channel cuts the pulse
    // short but still enforces the gap.
    always_comb begin
        state_d   = state_q;
        eng_cnt_d = eng_cnt_q;
        active_d  = active_q;
        last_d    = last_q;
        grant_v   = '0;
        case (state_q)
            ENG_IDLE: begin
                if (grant_found) begin
                    state_d            = ENG_PULSE;
                    eng_cnt_d          = PULSE_CYC - 32'd1;
                    active_d           = grant_idx;
                    last_d             = grant_idx;
                    grant_v[grant_idx] = 1'b1;
                end
            end
            ENG_PULSE: begin
                if (stop_v[active_q] || eng_cnt_q == 32'd0) begin
                    if (GAP_CYC == 32'd0) begin
                        state_d = ENG_IDLE;
                    end else begin
                        state_d   = ENG_GAP;
                        eng_cnt_d = GAP_CYC - 32'd1;
                    end
                end else begin
                    eng_cnt_d = eng_cnt_q - 32'd1;
                end
            end
            ENG_GAP: begin
                if (eng_cnt_q == 32'd0) begin
                    state_d = ENG_IDLE;
                end else begin
                    eng_cnt_d = eng_cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = ENG_IDLE;
            end
        endcase
    end

    // Top-level state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            state_q   <= ENG_IDLE;
            eng_cnt_q <= '0;
            active_q  <= '0;
            last_q    <= LAST_INIT;
        end else begin
            presc_q   <= presc_d;
            ready_q   <= 1'b1;
            err_q     <= err_d;
            state_q   <= state_d;
            eng_cnt_q <= eng_cnt_d;
            active_q  <= active_d;
            last_q    <= last_d;
        end
    end

    for (genvar i = 0; i < NUM_PUMPS; i++) begin : g_ch
        pump_channel_timer u_timer (
            .clk       (clk),
            .rst       (rst),
            .sec_tick  (sec_tick),
            .start     (start_v[i]),
            .stop      (stop_v[i]),
            .manual    (manual_v[i]),
            .grant     (grant_v[i]),
            .period_in (period_sel),
            .pump_en   (pump_en[i]),
            .pending   (pending[i])
        );
    end

    // Pump drive is one-hot on the active channel while pulsing.
    always_comb begin
        pump_out = '0;
        for (int i = 0; i < NUM_PUMPS; i++) begin
            pump_out[i] = (state_q == ENG_PULSE) && (active_q == CH_W'(i));
        end
    end

    assign cmd_ready = ready_q;
    assign cmd_err   = err_q;
    assign busy      = (state_q != ENG_IDLE);
    assign active_ch = active_q;

`ifdef PUMP_PULSE_COUNT_EN
    logic [15:0] pc_q [NUM_PUMPS];
    logic [15:0] pc_d [NUM_PUMPS];

    // Saturating per-channel grant counters.
    always_comb begin
        for (int i = 0; i < NUM_PUMPS; i++) begin
            pc_d[i] = pc_q[i];
            if (grant_v[i] && pc_q[i] != 16'hFFFF) begin
                pc_d[i] = pc_q[i] + 16'd1;
            end
        end
    end

    // Grant counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PUMPS; i++) begin
                pc_q[i] <= '0;
            end
        end else begin
            pc_q <= pc_d;
        end
    end

    // Flatten counters onto the output bus, channel 0 in the low bits.
    always_comb begin
        pulse_count = '0;
        for (int i = 0; i < NUM_PUMPS; i++) begin
            pulse_count[16*i +: 16] = pc_q[i];
        end
    end
`endif

endmodule
